sdp_ram_scheduler: RTL and testbench
====================================

SDP_RAM_SCHEDULER -- requirements
Module: sdp_ram_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the RAM word width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports a_wr_valid (in, 1), a_wr_ready (out, 1), a_wr_addr (in, ADDR_W), a_wr_data (in, DATA_W): write requester A.
REQ-006 SHALL have ports b_wr_valid (in, 1), b_wr_ready (out, 1), b_wr_addr (in, ADDR_W), b_wr_data (in, DATA_W): write requester B.
REQ-007 SHALL have ports rd_start (in, 1), rd_base (in, ADDR_W), rd_len (in, ADDR_W+1): read-burst command.
REQ-008 SHALL have ports rd_busy (out, 1), rd_done (out, 1), rd_valid (out, 1), rd_ready (in, 1), rd_data (out, DATA_W): read-burst status and stream.
REQ-009 SHALL have ports ram_wre (out, 1), ram_wad (out, ADDR_W), ram_di (out, DATA_W), ram_rad (out, ADDR_W), ram_dout (in, DATA_W): connection to a simple dual-port RAM with asynchronous read and synchronous write.

Function
REQ-010 Write arbiter SHALL grant at most one requester per cycle; the grant is combinational from the valid inputs and a registered round-robin pointer.
REQ-011 Only one valid requester: that requester SHALL be granted; both valid: the requester named by the pointer SHALL be granted.
REQ-012 x_wr_ready SHALL equal that requester's grant; a transfer occurs when valid and ready are both high.
REQ-013 On a transfer, ram_wre=1 with ram_wad/ram_di driven combinationally from the granted requester; otherwise ram_wre=0.
REQ-014 After a transfer by A the pointer SHALL favour B, and vice versa; with no transfer the pointer SHALL hold.
REQ-015 Read FSM SHALL have states IDLE, RUN, DONE.
REQ-016 IDLE: rd_start=1 SHALL capture rd_base into the address counter and rd_len into the remaining count; go to RUN if rd_len!=0, else to DONE.
REQ-017 rd_start SHALL be ignored outside IDLE; rd_busy=1 in RUN and DONE.
REQ-018 RUN: ram_rad SHALL equal the address counter; when the output register is empty or is being consumed (rd_valid&rd_ready) and words remain, ram_dout SHALL load into rd_data, rd_valid=1, address increments, remaining decrements.
REQ-019 First rd_valid SHALL assert 2 cycles after the cycle rd_start is sampled (1 cycle in IDLE->RUN, 1 load cycle), and sustain one word per cycle while rd_ready=1.
REQ-020 Address increment SHALL wrap modulo 2^ADDR_W (1023 -> 0).
REQ-021 rd_len up to 2^ADDR_W SHALL be legal; rd_data and rd_valid SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-022 When the last word is accepted, FSM SHALL go to DONE; DONE SHALL pulse rd_done for exactly one cycle, clear rd_valid, and return to IDLE.
REQ-023 Writes SHALL proceed concurrently with a read burst with no arbitration between the read and write ports.

Reset
REQ-024 While rst=1: FSM=IDLE, rd_valid=0, rd_busy=0, rd_done=0, rd_data=0, address and count=0, pointer favours A; a_wr_ready, b_wr_ready, ram_wre=0.
REQ-025 rst asserted mid-burst SHALL abandon the burst without asserting rd_done; ram_rad=0 while in reset.

Configuration
REQ-026 Macro SDP_RAW_STALL_EN SHALL select read-after-write hazard handling.
REQ-027 Defined: in RUN, a load SHALL be suppressed for any cycle with ram_wre=1 and ram_wad==ram_rad, retrying next cycle so the streamed word reflects the new data.
REQ-028 Undefined: no stall; a word read in the same cycle its address is written SHALL return the pre-write contents.

Verification
REQ-029 Both valid for 4 cycles, pointer at reset -> grants A,B,A,B; ram_wad follows the granted address.
REQ-030 Preload 0..7 with value=addr; rd_start base=0 len=8, rd_ready=1 -> rd_valid rises 2 cycles later, data 0..7 on consecutive cycles, rd_done one cycle after the last word.
REQ-031 base=1022 len=4 -> ram_rad sequence 1022,1023,0,1.
REQ-032 len=0 -> no rd_valid, rd_done pulses once, rd_busy high exactly one cycle.
REQ-033 rd_ready toggling 1,0,0,1 mid-burst -> rd_data stable while stalled, no word lost or duplicated; rst mid-burst -> all outputs at reset values next cycle, no rd_done.
REQ-034 Write 0xDEAD to address 5 in the cycle ram_rad=5 -> with SDP_RAW_STALL_EN streamed word is 0xDEAD after a one-cycle stall; without it, the old value.

Source files
------------

// File: rtl/sdp_ram_scheduler_if.sv
// sdp_ram_scheduler_if
// Groups every bus-level signal of the scheduler into one bundle.
//   Write requester A : a_wr_valid/a_wr_ready/a_wr_addr/a_wr_data
//   Write requester B : b_wr_valid/b_wr_ready/b_wr_addr/b_wr_data
//   Read command      : rd_start/rd_base/rd_len
//   Read stream       : rd_busy/rd_done/rd_valid/rd_ready/rd_data
//   RAM side          : ram_wre/ram_wad/ram_di/ram_rad/ram_dout
// The slave modport is the scheduler's view. The master modport is the view of
// whatever drives the requests and models the RAM.
interface sdp_ram_scheduler_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              a_wr_valid;
   logic              a_wr_ready;
   logic [ADDR_W-1:0] a_wr_addr;
   logic [DATA_W-1:0] a_wr_data;

   logic              b_wr_valid;
   logic              b_wr_ready;
   logic [ADDR_W-1:0] b_wr_addr;
   logic [DATA_W-1:0] b_wr_data;

   logic              rd_start;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W:0]   rd_len;

   logic              rd_busy;
   logic              rd_done;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   logic              ram_wre;
   logic [ADDR_W-1:0] ram_wad;
   logic [DATA_W-1:0] ram_di;
   logic [ADDR_W-1:0] ram_rad;
   logic [DATA_W-1:0] ram_dout;

   modport slave (
      input  a_wr_valid, a_wr_addr, a_wr_data,
      input  b_wr_valid, b_wr_addr, b_wr_data,
      input  rd_start, rd_base, rd_len, rd_ready, ram_dout,
      output a_wr_ready, b_wr_ready,
      output rd_busy, rd_done, rd_valid, rd_data,
      output ram_wre, ram_wad, ram_di, ram_rad
   );

   modport master (
      output a_wr_valid, a_wr_addr, a_wr_data,
      output b_wr_valid, b_wr_addr, b_wr_data,
      output rd_start, rd_base, rd_len, rd_ready, ram_dout,
      input  a_wr_ready, b_wr_ready,
      input  rd_busy, rd_done, rd_valid, rd_data,
      input  ram_wre, ram_wad, ram_di, ram_rad
   );
endinterface

// File: rtl/sdp_ram_scheduler.sv
// sdp_ram_scheduler
// Front end for a simple dual-port RAM (async read, sync write).
//   - Two write requesters (A, B) share the write port through a round-robin
//     arbiter. The grant is combinational and the pointer is registered.
//   - A read-burst engine streams rd_len words starting at rd_base through a
//     one-word valid/ready output register. The address wraps modulo 2^ADDR_W.
//   - Reads and writes use separate RAM ports and never arbitrate.
// Ports: clk, rst (sync, active-high), bus (sdp_ram_scheduler_if.slave).
// Optional feature: define SDP_RAW_STALL_EN to hold off a read load in any cycle
// where the same address is being written, so the stream returns the new data.
// Without it, a same-cycle read returns the pre-write contents.
//
// Read FSM
//   state   | meaning
//   IDLE    | waiting for rd_start
//   RUN     | streaming words, rd_busy=1
//   DONE    | one-cycle rd_done pulse, rd_busy=1
module sdp_ram_scheduler #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   sdp_ram_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rd_state_e;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ptr_q, ptr_d;      // 0: A wins a tie, 1: B wins a tie

   logic              grant_a, grant_b;
   logic              consume;
   logic              raw_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   // Write arbiter. A valid requester always wins when it is alone. When both
   // are valid, the pointer decides. Every grant is a transfer because ready
   // equals grant.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      ptr_d   = ptr_q;
      if (!rst) begin
         if (bus.a_wr_valid && (!bus.b_wr_valid || !ptr_q)) begin
            grant_a = 1'b1;
         end else if (bus.b_wr_valid) begin
            grant_b = 1'b1;
         end
      end
      if (grant_a) begin
         ptr_d = 1'b1;
      end else if (grant_b) begin
         ptr_d = 1'b0;
      end
   end

   assign bus.a_wr_ready = grant_a;
   assign bus.b_wr_ready = grant_b;
   assign bus.ram_wre    = grant_a | grant_b;
   assign bus.ram_wad    = grant_b ? bus.b_wr_addr : bus.a_wr_addr;
   assign bus.ram_di     = grant_b ? bus.b_wr_data : bus.a_wr_data;

`ifdef SDP_RAW_STALL_EN
   assign raw_hit = bus.ram_wre && (bus.ram_wad == bus.ram_rad);
`else
   assign raw_hit = 1'b0;
`endif

   assign consume = valid_q && bus.rd_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.rd_start) begin
               addr_d  = bus.rd_base;
               rem_d   = bus.rd_len;
               state_d = (bus.rd_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (consume) begin
               valid_d = 1'b0;
            end
            // The output register refills when it is empty or being drained.
            // A RAW hit only delays the refill. The same address is retried
            // on the next cycle.
            if ((!valid_q || consume) && (rem_q != '0) && !raw_hit) begin
               data_d  = bus.ram_dout;
               valid_d = 1'b1;
               addr_d  = addr_q + ADDR_ONE;
               rem_d   = rem_q - LEN_ONE;
            end else if (consume && (rem_q == '0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // These outputs are gated by rst so they read as their reset values during
   // the whole reset cycle, not only after the first edge.
   assign bus.rd_busy  = !rst && (state_q != ST_IDLE);
   assign bus.rd_done  = !rst && (state_q == ST_DONE);
   assign bus.rd_valid = !rst && valid_q;
   assign bus.rd_data  = rst ? '0 : data_q;
   assign bus.ram_rad  = rst ? '0 : addr_q;

endmodule

// File: tb/tb_sdp_ram_scheduler.sv
module tb_sdp_ram_scheduler;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;
`ifdef SDP_RAW_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdp_ram_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sdp_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // The RAM device: async read, sync write.
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk) if (bus.ram_wre) ram_mem[bus.ram_wad] <= bus.ram_di;
   assign bus.ram_dout = ram_mem[bus.ram_rad];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: contents of memory and the round-robin winner rule.
   logic [DW-1:0] ref_mem [DEPTH];
   bit            favour_b;
   int            winner;   // 0 none, 1 A, 2 B

   always @(negedge clk) begin
      if (rst) begin
         favour_b = 1'b0;
      end else begin
         if (bus.a_wr_valid && bus.b_wr_valid) winner = favour_b ? 2 : 1;
         else if (bus.a_wr_valid)              winner = 1;
         else if (bus.b_wr_valid)              winner = 2;
         else                                  winner = 0;
         check("a_wr_ready", bus.a_wr_ready, winner == 1);
         check("b_wr_ready", bus.b_wr_ready, winner == 2);
         check("ram_wre", bus.ram_wre, winner != 0);
         if (winner == 1) begin
            check("ram_wad_a", bus.ram_wad, bus.a_wr_addr);
            check("ram_di_a", bus.ram_di, bus.a_wr_data);
            ref_mem[bus.a_wr_addr] = bus.a_wr_data;
            favour_b = 1'b1;
         end else if (winner == 2) begin
            check("ram_wad_b", bus.ram_wad, bus.b_wr_addr);
            check("ram_di_b", bus.ram_di, bus.b_wr_data);
            ref_mem[bus.b_wr_addr] = bus.b_wr_data;
            favour_b = 1'b0;
         end
      end
   end

   // Read-stream scoreboard.
   logic [DW-1:0] exp_q [$];
   int            first_valid_cyc = -1;
   int            last_acc_cyc    = -1;
   int            done_cyc        = -1;
   int            done_cnt        = 0;
   int            busy_cnt        = 0;
   bit            prev_stall      = 1'b0;
   logic [DW-1:0] prev_data;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", bus.rd_valid, 1);
            check("hold_data", bus.rd_data, prev_data);
         end
         if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_data: unexpected word %0h, none expected", bus.rd_data);
            end else begin
               check("rd_data", bus.rd_data, exp_q.pop_front());
            end
            last_acc_cyc = cyc;
         end
         prev_stall = bus.rd_valid && !bus.rd_ready;
         prev_data  = bus.rd_data;
         if (bus.rd_busy) busy_cnt++;
         if (bus.rd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   bit ready_pat [4];

   function automatic bit pick_ready(input int mode, input int k);
      if (mode == 1) return 1'b1;
      if (mode == 2) return ready_pat[k % 4];
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic drive_writes(input bit en);
      if (en) begin
         bus.a_wr_valid = 1'($urandom_range(0, 1));
         bus.a_wr_addr  = AW'(512 + $urandom_range(0, 255));
         bus.a_wr_data  = $urandom;
         bus.b_wr_valid = 1'($urandom_range(0, 1));
         bus.b_wr_addr  = AW'(512 + $urandom_range(0, 255));
         bus.b_wr_data  = $urandom;
      end else begin
         bus.a_wr_valid = 1'b0;
         bus.b_wr_valid = 1'b0;
      end
   endtask

   task automatic wr_a(input int addr, input logic [DW-1:0] data);
      @(posedge clk); #1;
      bus.a_wr_valid = 1'b1;
      bus.a_wr_addr  = AW'(addr);
      bus.a_wr_data  = data;
      @(posedge clk); #1;
      bus.a_wr_valid = 1'b0;
   endtask

   // mode: 0 random rd_ready, 1 always ready, 2 pattern 1,0,0,1.
   // raw: write 0xDEAD to the base address in the first RUN cycle.
   task automatic run_burst(input int base, input int len, input int mode,
                            input bit raw, input bit rand_wr);
      int  d0, b0, sc;
      bit  got;
      if (raw) exp_q.push_back(STALL_EN ? 32'hDEAD : ref_mem[base]);
      else for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % DEPTH]);
      d0 = done_cnt;
      b0 = busy_cnt;
      first_valid_cyc = -1;
      last_acc_cyc    = -1;
      @(posedge clk); #1;
      bus.rd_start = 1'b1;
      bus.rd_base  = AW'(base);
      bus.rd_len   = (AW+1)'(len);
      bus.rd_ready = pick_ready(mode, 0);
      sc  = cyc;
      got = 1'b0;
      for (int k = 0; k < 400 + 8 * len; k++) begin
         @(posedge clk); #1;
         bus.rd_start = 1'b0;
         if (raw) begin
            bus.a_wr_valid = (cyc == sc + 1);
            bus.a_wr_addr  = AW'(base);
            bus.a_wr_data  = 32'hDEAD;
         end else begin
            drive_writes(rand_wr);
         end
         bus.rd_ready = pick_ready(mode, k);
         if (mode == 1 && !raw && k < len)
            check("ram_rad", bus.ram_rad, (base + k) % DEPTH);
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      drive_writes(1'b0);
      bus.rd_ready = 1'b0;
      check("done_seen", got, 1);
      @(posedge clk); #1;
      check("done_once", done_cnt - d0, 1);
      check("idle_after_done", bus.rd_busy, 0);
      check("queue_drained", exp_q.size(), 0);
      if (len > 0) begin
         check("first_valid_lat", first_valid_cyc - sc, (raw && STALL_EN) ? 3 : 2);
         check("done_after_last", done_cyc - last_acc_cyc, 1);
         if (mode == 1 && !raw) check("stream_span", last_acc_cyc - first_valid_cyc, len - 1);
      end else begin
         check("no_valid_len0", first_valid_cyc, -1);
         check("busy_len0", busy_cnt - b0, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int d0;

   initial begin
      ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;
      rst = 1'b1;
      bus.a_wr_valid = 1'b1; bus.a_wr_addr = '0; bus.a_wr_data = '0;
      bus.b_wr_valid = 1'b1; bus.b_wr_addr = '0; bus.b_wr_data = '0;
      bus.rd_start = 1'b1; bus.rd_base = '0; bus.rd_len = 11'd4; bus.rd_ready = 1'b1;

      // Reset values while requests are pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_ready", bus.a_wr_ready, 0);
      check("rst_b_ready", bus.b_wr_ready, 0);
      check("rst_wre", bus.ram_wre, 0);
      check("rst_valid", bus.rd_valid, 0);
      check("rst_busy", bus.rd_busy, 0);
      check("rst_done", bus.rd_done, 0);
      check("rst_data", bus.rd_data, 0);
      check("rst_rad", bus.ram_rad, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.rd_start = 1'b0;
      bus.a_wr_valid = 1'b0;
      bus.b_wr_valid = 1'b0;

      // Both requesters valid for 4 cycles from reset: A,B,A,B.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.a_wr_valid = 1'b1; bus.a_wr_addr = AW'(100); bus.a_wr_data = 32'hA0 + i;
         bus.b_wr_valid = 1'b1; bus.b_wr_addr = AW'(200); bus.b_wr_data = 32'hB0 + i;
         #1;
         check("rr_grant_a", bus.a_wr_ready, (i % 2) == 0);
         check("rr_wad", bus.ram_wad, ((i % 2) == 0) ? 100 : 200);
      end
      @(posedge clk); #1;
      drive_writes(1'b0);

      // Fill the whole RAM with known contents.
      for (int i = 0; i < DEPTH; i++) wr_a(i, $urandom);
      for (int i = 0; i < 8; i++) wr_a(i, i);

      run_burst(0, 8, 1, 1'b0, 1'b0);      // data 0..7, back to back
      run_burst(1022, 4, 1, 1'b0, 1'b0);   // address wrap 1022,1023,0,1
      run_burst(0, 0, 1, 1'b0, 1'b0);      // empty burst
      run_burst(16, 8, 2, 1'b0, 1'b0);     // rd_ready 1,0,0,1 stalls

      wr_a(5, 32'h1111);
      run_burst(5, 1, 1, 1'b1, 1'b0);      // read/write to the same address

      // Reset in the middle of a burst: abandoned, no rd_done.
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.rd_start = 1'b1; bus.rd_base = AW'(40); bus.rd_len = 11'd20; bus.rd_ready = 1'b0;
      @(posedge clk); #1;
      bus.rd_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_busy", bus.rd_busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.rd_valid, 0);
      check("mid_rst_busy", bus.rd_busy, 0);
      check("mid_rst_rad", bus.ram_rad, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_valid", bus.rd_valid, 0);
      check("post_rst_busy", bus.rd_busy, 0);
      check("post_rst_data", bus.rd_data, 0);
      check("post_rst_rad", bus.ram_rad, 0);
      repeat (6) @(posedge clk);
      #1;
      check("no_done_after_rst", done_cnt - d0, 0);
      check("idle_after_rst", bus.rd_busy, 0);

      // Random bursts with concurrent writes outside the burst region.
      for (int n = 0; n < 20; n++)
         run_burst($urandom_range(0, 400), $urandom_range(0, 40), $urandom_range(0, 2), 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
